// File: rtl/tc16_to_sm9.sv
`default_nettype none
// ============================================================================
//  Module   : tc16_to_sm9
//  Purpose  : Converts a 16-bit two's-complement accumulator value into a
//             9-bit sign-magnitude sample. The magnitude is optionally
//             right-shifted, then clamped to 8 bits. Two-stage valid/ready
//             pipeline with a saturating count of clamped results.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SHIFT      : logical right shift (0..8) applied to |in_data| before clamp
//  Ports
//    clk        : rising-edge clock
//    rst        : asynchronous, active-high reset
//    in_valid   : in_data holds a valid sample
//    in_ready   : block accepts a sample this cycle
//    in_data    : 16-bit two's-complement input
//    out_valid  : out_data / sat_flag hold a valid result
//    out_ready  : consumer accepts the result this cycle
//    out_data   : {sign, magnitude[7:0]}, never negative zero
//    sat_flag   : current out_data was clamped
//    sat_count  : saturating count of transferred clamped results
//    clr_count  : synchronous clear of sat_count (wins over increment)
// ============================================================================
module tc16_to_sm9 #(
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_data,
    output logic        sat_flag,
    output logic [15:0] sat_count,
    input  logic        clr_count
);

    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    // Stage 1: sign and 17-bit absolute value
    logic        s1_valid_q, s1_valid_d;
    logic        s1_neg_q,   s1_neg_d;
    logic [16:0] s1_mag_q,   s1_mag_d;

    // Stage 2: shifted, clamped sign-magnitude result
    logic        s2_valid_q, s2_valid_d;
    logic [8:0]  s2_data_q,  s2_data_d;
    logic        s2_sat_q,   s2_sat_d;

    logic [15:0] sat_count_q, sat_count_d;

    logic        advance;
    logic        out_xfer;
    logic [16:0] in_ext;
    logic [16:0] abs_mag;
    logic [16:0] shifted_mag;
    logic        shifted_sat;
    logic [7:0]  mag8;

    // S2 can take new data when it is empty or is being drained this cycle;
    // S1 moves on under the same condition.
    assign advance  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || advance;
    assign out_xfer = s2_valid_q && out_ready;

    // Widen before negating so that -32768 becomes +32768 without overflow.
    assign in_ext  = {in_data[15], in_data};
    assign abs_mag = in_data[15] ? (17'd0 - in_ext) : in_ext;

    assign shifted_mag = s1_mag_q >> SHIFT;
    assign shifted_sat = |shifted_mag[16:8];
    assign mag8        = shifted_sat ? 8'hFF : shifted_mag[7:0];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_neg_d    = s1_neg_q;
        s1_mag_d    = s1_mag_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_sat_d    = s2_sat_q;
        sat_count_d = sat_count_q;

        // When in_ready is high, S1 is either empty or handing its sample to
        // S2 this edge, so it can always take whatever is on the input.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_neg_d = in_data[15];
            s1_mag_d = abs_mag;
        end

        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                // Sign is dropped when the magnitude is zero: no negative zero.
                s2_data_d = {s1_neg_q && (mag8 != 8'd0), mag8};
                s2_sat_d  = shifted_sat;
            end
        end

        if (clr_count) begin
            sat_count_d = 16'd0;
        end else if (out_xfer && s2_sat_q && (sat_count_q != C_COUNT_MAX)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_mag_q    <= 17'd0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= 9'd0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_neg_q    <= s1_neg_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign sat_flag  = s2_sat_q;
    assign sat_count = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tc16_to_sm9.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc16_to_sm9
//  Purpose  : Self-checking bench for tc16_to_sm9. Two instances (SHIFT=0 and
//             SHIFT=4) share all inputs; expected results are queued on each
//             input transfer and compared on each output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc16_to_sm9;

    typedef struct packed {
        logic [8:0] e0;
        logic       e0s;
        logic [8:0] e4;
        logic       e4s;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready0, out_valid0, sat_flag0;
    logic [8:0]  out_data0;
    logic [15:0] sat_count0;
    logic        in_ready4, out_valid4, sat_flag4;
    logic [8:0]  out_data4;
    logic [15:0] sat_count4;

    exp_t        cur_exp;
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    tc16_to_sm9 #(.SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .sat_flag(sat_flag0), .sat_count(sat_count0),
        .clr_count(clr_count)
    );

    tc16_to_sm9 #(.SHIFT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .sat_flag(sat_flag4), .sat_count(sat_count4),
        .clr_count(clr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference conversion in plain integer arithmetic: {sat, sign, mag[7:0]}
    function automatic logic [9:0] model(input logic [15:0] d, input int sh);
        int  v;
        int  m;
        logic sat;
        v = int'($signed(d));
        if (v < 0) v = -v;
        v = v >> sh;
        sat = (v > 255);
        m = sat ? 255 : v;
        return {sat, d[15] && (m != 0), m[7:0]};
    endfunction

    task automatic set_in(input logic [15:0] d, input exp_t e);
        in_data = d;
        cur_exp = e;
    endtask

    task automatic set_in_model(input logic [15:0] d);
        logic [9:0] r0;
        logic [9:0] r4;
        r0 = model(d, 0);
        r4 = model(d, 4);
        set_in(d, '{e0: r0[8:0], e0s: r0[9], e4: r4[8:0], e4s: r4[9]});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds in_valid until the sample is taken; returns 1 ns after that edge.
    task automatic send();
        logic acc;
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: transfers are judged at the falling edge, where inputs and
    // registered outputs are stable until the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_data=0x%0h with nothing pending, required no output", out_data0);
                end else begin
                    e = sb.pop_front();
                    check("s0_data", 32'(out_data0), 32'(e.e0));
                    check("s0_sat",  32'(sat_flag0), 32'(e.e0s));
                    check("s4_valid", 32'(out_valid4), 32'd1);
                    check("s4_data", 32'(out_data4), 32'(e.e4));
                    check("s4_sat",  32'(sat_flag4), 32'(e.e4s));
                end
            end
            if (in_valid && in_ready0) sb.push_back(cur_exp);
        end
    end

    vec_t vec[13];

    initial begin
        logic acc;
        int   ramp;
        int   stall_accepts;

        vec[0]  = '{16'h0003, '{9'h003, 1'b0, 9'h000, 1'b0}};
        vec[1]  = '{16'hFFFD, '{9'h103, 1'b0, 9'h000, 1'b0}};
        vec[2]  = '{16'h00FF, '{9'h0FF, 1'b0, 9'h00F, 1'b0}};
        vec[3]  = '{16'hFF01, '{9'h1FF, 1'b0, 9'h10F, 1'b0}};
        vec[4]  = '{16'h0100, '{9'h0FF, 1'b1, 9'h010, 1'b0}};
        vec[5]  = '{16'h8000, '{9'h1FF, 1'b1, 9'h1FF, 1'b1}};
        vec[6]  = '{16'h7FFF, '{9'h0FF, 1'b1, 9'h0FF, 1'b1}};
        vec[7]  = '{16'h0000, '{9'h000, 1'b0, 9'h000, 1'b0}};
        vec[8]  = '{16'hFFDB, '{9'h125, 1'b0, 9'h102, 1'b0}};
        vec[9]  = '{16'hFFFB, '{9'h105, 1'b0, 9'h000, 1'b0}};
        vec[10] = '{16'h0FFF, '{9'h0FF, 1'b1, 9'h0FF, 1'b0}};
        vec[11] = '{16'h1000, '{9'h0FF, 1'b1, 9'h0FF, 1'b1}};
        vec[12] = '{16'hFF00, '{9'h1FF, 1'b1, 9'h110, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        cur_exp   = '0;

        // ---------------- reset state ----------------
        cycles(2);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_out_data",  32'(out_data0),  32'd0);
        check("rst_sat_flag",  32'(sat_flag0),  32'd0);
        check("rst_sat_count", 32'(sat_count0), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready0", 32'(in_ready0), 32'd1);
        check("post_rst_in_ready4", 32'(in_ready4), 32'd1);

        // ---------------- latency: accepted at N, visible after N+1 --------
        set_in(vec[0].din, vec[0].e);
        send();
        in_valid = 1'b0;
        check("lat_not_early", 32'(out_valid0), 32'd0);
        cycles(1);
        check("lat_valid", 32'(out_valid0), 32'd1);
        check("lat_data",  32'(out_data0),  32'h003);
        cycles(2);

        // ---------------- table, back-to-back ----------------
        for (int i = 0; i < 13; i++) begin
            set_in(vec[i].din, vec[i].e);
            send();
        end
        in_valid = 1'b0;
        cycles(4);
        check("table_drain", sb.size(), 32'd0);

        // ---------------- back-pressure with a ramp ----------------
        ramp = 0;
        stall_accepts = 0;
        set_in_model(16'd10);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && ramp < 10; cyc++) begin
            out_ready = (cyc >= 4);
            @(negedge clk);
            acc = in_ready0;
            if (cyc < 4 && acc) stall_accepts++;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_ready_low", 32'(in_ready0), 32'd0);
                check("bp_hold_valid",   32'(out_valid0), 32'd1);
                check("bp_hold_data",    32'(out_data0), 32'(model(16'd10, 0)));
            end
            @(posedge clk);
            #1;
            if (acc) begin
                ramp++;
                set_in_model(16'(10 + ramp));
            end
            if (ramp >= 10) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_stall_accepts", 32'(stall_accepts), 32'd2);
        cycles(4);
        check("bp_drain", sb.size(), 32'd0);

        // ---------------- counter ----------------
        clr_count = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        check("cnt_clear", 32'(sat_count0), 32'd0);
        set_in_model(16'd256);
        repeat (3) send();
        in_valid = 1'b0;
        cycles(3);
        check("cnt_three", 32'(sat_count0), 32'd3);
        check("cnt_s4_none", 32'(sat_count4), 32'd0);

        send();
        in_valid = 1'b0;
        cycles(1);
        clr_count = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        check("cnt_clr_priority", 32'(sat_count0), 32'd0);
        check("cnt_clr_xfer_done", 32'(out_valid0), 32'd0);

        set_in_model(16'h8000);
        in_valid = 1'b1;
        cycles(65540);
        in_valid = 1'b0;
        cycles(3);
        check("cnt_sat0", 32'(sat_count0), 32'hFFFF);
        check("cnt_sat4", 32'(sat_count4), 32'hFFFF);
        send();
        in_valid = 1'b0;
        cycles(3);
        check("cnt_hold_max", 32'(sat_count0), 32'hFFFF);

        // ---------------- mid-stream reset ----------------
        out_ready = 1'b0;
        set_in_model(16'h0011);
        in_valid = 1'b1;
        cycles(2);
        check("mr_full", 32'(out_valid0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid0), 32'd0);
        check("mr_sat_count0", 32'(sat_count0), 32'd0);
        check("mr_sat_count4", 32'(sat_count4), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready0), 32'd1);
        cycles(2);
        check("mr_no_stale", 32'(out_valid0), 32'd0);
        set_in_model(16'h0042);
        send();
        in_valid = 1'b0;
        cycles(1);
        check("mr_first_data", 32'(out_data0), 32'h042);
        cycles(3);
        check("mr_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc16_to_sm9.md
TC16_TO_SM9 -- requirements
Module: tc16_to_sm9

Interface
REQ-001 Parameter SHIFT, default 0, meaning: right shift (0..8) applied to the magnitude before saturation.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_data holds a valid sample.
REQ-005 in_ready  output  1  block accepts a sample this cycle.
REQ-006 in_data  input  16  two's-complement accumulator value.
REQ-007 out_valid  output  1  out_data/sat_flag hold a valid result.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 out_data  output  9  sign-magnitude result: bit 8 is the sign (1 = negative), bits 7:0 are the magnitude.
REQ-010 sat_flag  output  1  the current out_data was clamped; aligned with out_data.
REQ-011 sat_count  output  16  running count of transferred saturated results.
REQ-012 clr_count  input  1  synchronous clear of sat_count.
REQ-013 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 The datapath SHALL be a two-stage pipeline: S1 registers the sign and the 17-bit absolute value; S2 registers the shifted, saturated sign-magnitude result.
REQ-017 S2 SHALL load when it is empty or an output transfer occurs in that cycle; S1 SHALL advance under the same condition.
REQ-018 in_ready SHALL equal (!S1_valid || !S2_valid || out_ready); the combinational path from out_ready to in_ready is permitted.
REQ-019 With out_ready held high, a sample accepted at edge N SHALL be presented with out_valid=1 after edge N+1 (2-cycle latency), at a throughput of one sample per cycle.
REQ-020 Samples SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-021 While out_valid=1 and out_ready=0, out_data and sat_flag SHALL hold stable.
REQ-022 The magnitude SHALL be |in_data| computed in 17 bits, so that -32768 yields 32768 with no overflow.
REQ-023 The shifted magnitude m SHALL be magnitude >> SHIFT (logical shift), which truncates toward zero.
REQ-024 If m > 255, then out_data[7:0] SHALL be 255 and sat_flag SHALL be 1; otherwise out_data[7:0] SHALL be m and sat_flag SHALL be 0.
REQ-025 out_data[8] SHALL be the input sign, except when out_data[7:0]=0, where it SHALL be 0 (the block never emits negative zero).
REQ-026 sat_count SHALL increment by 1 on each output transfer with sat_flag=1 and SHALL hold at 16'hFFFF, never wrapping.
REQ-027 When clr_count=1, sat_count SHALL become 0 at that edge, taking priority over a simultaneous increment.
REQ-028 An input transfer and an output transfer in the same cycle SHALL both complete.

Reset
REQ-029 While rst=1, out_valid, out_data, sat_flag and sat_count SHALL be 0, and both stage-valid flags SHALL be 0.
REQ-030 With both stages empty, in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight samples immediately, with no partial output after release.

Verification
REQ-032 Basic conversion: in_data 16'd3 then 16'hFFFD, out_ready=1 -> out_data 9'h003 then 9'h103, both with sat_flag=0, each 2 cycles after acceptance.
REQ-033 Saturation boundaries with SHIFT=0:
- 255 -> 9'h0FF, sat 0
- -255 -> 9'h1FF, sat 0
- 256 -> 9'h0FF, sat 1
- -32768 -> 9'h1FF, sat 1
- 32767 -> 9'h0FF, sat 1
- 0 -> 9'h000
REQ-034 Shift and zero with SHIFT=4:
- -37 -> 9'h102
- -5 -> 9'h000 (no negative zero)
- 4095 -> 9'h0FF, sat 0
- 4096 -> 9'h0FF, sat 1
REQ-035 Back-pressure: continuous in_valid with an incrementing ramp, out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, out_data stays stable, and after release the full ramp is received in order with no gaps or repeats.
REQ-036 Counter behaviour:
- 3 saturated transfers -> sat_count=3.
- Saturated transfer with clr_count=1 in the same cycle -> sat_count=0.
- Preload to 16'hFFFF via 65535 saturated transfers, then one more -> sat_count stays 16'hFFFF.
REQ-037 Mid-stream reset: rst pulsed while both stages are valid -> out_valid=0 and sat_count=0 immediately, and the first output after release is the first sample accepted after release.
